arbitro_eventos: RTL and testbench
==================================

# arbitro_eventos

Serializes the debounced button and sensor lines (test, medicina, energia, ultrasonido, fotocelda) into a single event stream for the pet's main state machine. Each release (1→0 transition) of a debounced line becomes one pending request. A fixed-priority arbiter grants the pending requests one at a time over a valid/ready handshake, and a programmable cooldown follows each grant. The block sits between the debounce stage and the mode/state controller, so the controller never sees two simultaneous commands.

## Interface
- `COOLDOWN`, default 50000: number of idle cycles enforced after each accepted event (1 ms at 50 MHz). 0 disables the cooldown.
- `CNT_W`, default 16: width of the cooldown counter. Must satisfy COOLDOWN < 2^CNT_W.
- `clk` in, 1: system clock. All state changes on the rising edge.
- `reset` in, 1: asynchronous, active-high reset. Clears all state immediately.
- `ev_in` in, 5: debounced levels, synchronous to `clk`. Bit 0 test, 1 medicina, 2 energia, 3 ultrasonido, 4 fotocelda.
- `ev_ready` in, 1: consumer accepts the offered event.
- `ev_valid` out, 1: an event is offered on `ev_code`.
- `ev_code` out, 3: index 0–4 of the offered source. Stable while `ev_valid` is high.
- `pendientes` out, 5: pending-request vector, same bit mapping as `ev_in`.
- `perdidos` out, 8: saturating count of coalesced (lost) events.
- `busy` out, 1: high while in the COOLDOWN state.

## Operation
- Edge capture:
  - `ev_prev` registers `ev_in` every cycle.
  - A falling edge on bit i is `ev_prev[i] & ~ev_in[i]`. It sets `pendientes[i]`.
  - Edges are captured in every FSM state, including OFFER and COOLDOWN.
- Coalescing:
  - A falling edge on a bit that is already pending, and is not being cleared in the same cycle, increments `perdidos`.
  - `perdidos` saturates at 255 and does not wrap.
  - Several coalesced edges in one cycle add their count, still saturating.
- Handshake-cycle collision: if a new edge arrives on the granted source in the same cycle as its handshake, the bit stays set. This is not counted as lost.
- FSM states:
  - IDLE: if `pendientes` ≠ 0, latch the lowest set index into `ev_code` (priority test > medicina > energia > ultrasonido > fotocelda), assert `ev_valid`, and go to OFFER. Otherwise remain in IDLE.
  - OFFER: hold `ev_valid` = 1 and `ev_code` unchanged until `ev_valid & ev_ready` is sampled.
    - Higher-priority arrivals do not preempt the offer.
    - On handshake: clear the granted pending bit and drop `ev_valid`.
    - Then go to COOLDOWN with the counter loaded to COOLDOWN−1, or go straight to IDLE if COOLDOWN = 0.
  - COOLDOWN: `busy` = 1. Decrement the counter each cycle. When the counter reads 0, go to IDLE.
- `ev_ready` is ignored outside OFFER.
- Reset values:
  - `ev_valid` = 0, `ev_code` = 0, `pendientes` = 0, `perdidos` = 0, `busy` = 0.
  - `ev_prev` = 0, state = IDLE, counter = 0.
  - A line held high through reset and then released after reset deassertion produces one event.
- Reset mid-operation: an offered event and all pending requests are discarded. No event is emitted after reset unless a new falling edge occurs.

## Timing
- Edge latency:
  - Falling edge sampled at rising edge k → `pendientes[i]` high after edge k.
  - If the FSM is in IDLE, `ev_valid` rises after edge k+1 (2-cycle latency).
- Handshake:
  - Completed at edge m → `ev_valid` low after edge m.
  - `busy` is high for exactly COOLDOWN cycles.
  - The next `ev_valid` rises after edge m+COOLDOWN+1 at the earliest.
  - With COOLDOWN = 0, back-to-back events are spaced 2 cycles apart (valid, IDLE, valid).
- `ev_ready` held permanently high: each event costs COOLDOWN+2 cycles, of which `ev_valid` is high for 1.
- Simultaneous edges on several sources in one cycle: all are captured and emitted in priority order across successive grants.

## Test plan
1. COOLDOWN=4, `ev_ready`=1. Pulse `ev_in[2]` 1→0 once → one event with `ev_code`=2. `ev_valid` high 1 cycle, 2 cycles after the edge. `busy` high 4 cycles. `perdidos`=0.
2. COOLDOWN=4. Drop bits 4, 1 and 0 in the same cycle → codes 0, 1, 4 in that order, with `ev_valid` rising edges spaced 6 cycles apart. `pendientes` goes 10011 → 10010 → 10000 → 00000.
3. `ev_ready`=0 for 20 cycles while code 3 is offered; raise bit 0 and drop it mid-offer → code 3 is held stable throughout the stall. Code 0 is offered after the cooldown.
4. `ev_ready`=0. Produce 300 falling edges on bit 1 → `pendientes[1]`=1 and `perdidos` saturates at 255. After release exactly one code-1 event is emitted.
5. Falling edge on bit 2 in the same cycle as the handshake of code 2 → `pendientes[2]` stays 1 and `perdidos` does not increment. A second code-2 event follows after the cooldown.
6. Assert `reset` during OFFER and during COOLDOWN → all outputs return to 0 immediately. No event is emitted after release without a new edge.

Source files
------------

// File: rtl/arbitro_eventos.sv
// arbitro_eventos: serializes falling edges of five debounced lines into one prioritized event stream
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   ev_in[4:0]        debounced levels (0 test, 1 medicina, 2 energia, 3 ultrasonido, 4 fotocelda)
//   ev_ready          consumer accepts the offered event
//   ev_valid/ev_code  offered event and its source index
//   pendientes        pending-request vector
//   perdidos          saturating count of coalesced edges
//   busy              cooldown in progress
module arbitro_eventos #(
    parameter int COOLDOWN = 50000,
    parameter int CNT_W    = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] ev_in,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [2:0] ev_code,
    output logic [4:0] pendientes,
    output logic [7:0] perdidos,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, OFFER, COOL} state_t;
    state_t           state_q, state_d;
    logic [4:0]       prev_q, pend_q, pend_d, fall, clr, lost;
    logic [7:0]       perd_q, perd_d;
    logic [2:0]       code_q, code_d, first, lost_n;
    logic             valid_q, valid_d, hs;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       sum;

    assign fall   = prev_q & ~ev_in;
    assign hs     = state_q == OFFER && ev_ready;
    assign clr    = hs ? 5'b1 << code_q : 5'b0;
    // a new edge on the bit being granted re-arms it instead of counting as lost
    assign lost   = fall & pend_q & ~clr;
    assign lost_n = 3'(lost[0]) + 3'(lost[1]) + 3'(lost[2]) + 3'(lost[3]) + 3'(lost[4]);
    assign sum    = {1'b0, perd_q} + {6'b0, lost_n};
    assign perd_d = sum[8] ? 8'hff : sum[7:0];
    assign pend_d = (pend_q & ~clr) | fall;
    assign first  = pend_q[0] ? 3'd0 : pend_q[1] ? 3'd1 : pend_q[2] ? 3'd2 : pend_q[3] ? 3'd3 : 3'd4;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (|pend_q) begin
                state_d = OFFER;
                code_d  = first;
                valid_d = 1'b1;
            end
            OFFER: if (ev_ready) begin
                valid_d = 1'b0;
                state_d = COOLDOWN == 0 ? IDLE : COOL;
                cnt_d   = CNT_W'(COOLDOWN - 1);
            end
            default: if (cnt_q == '0) state_d = IDLE;
                     else cnt_d = cnt_q - CNT_W'(1);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            prev_q  <= '0;
            pend_q  <= '0;
            perd_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            prev_q  <= ev_in;
            pend_q  <= pend_d;
            perd_q  <= perd_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ev_valid   = valid_q;
    assign ev_code    = code_q;
    assign pendientes = pend_q;
    assign perdidos   = perd_q;
    assign busy       = state_q == COOL;
endmodule

// File: tb/tb_arbitro_eventos.sv
// tb_arbitro_eventos: directed scoreboard bench for arbitro_eventos with COOLDOWN=4
module tb_arbitro_eventos;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] ev_in = '0;
    logic       ev_ready = 1'b1;
    logic       ev_valid;
    logic [2:0] ev_code;
    logic [4:0] pendientes;
    logic [7:0] perdidos;
    logic       busy;

    typedef struct {
        logic [2:0] code;
        int         rise;
    } exp_t;
    exp_t sb[$];

    int vec = 0;
    int errs = 0;
    int cyc = 0;

    arbitro_eventos #(.COOLDOWN(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .ev_in(ev_in), .ev_ready(ev_ready),
        .ev_valid(ev_valid), .ev_code(ev_code), .pendientes(pendientes),
        .perdidos(perdidos), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [2:0] c, input int r);
        exp_t e;
        e.code = c;
        e.rise = r;
        sb.push_back(e);
    endtask

    task automatic drv();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int n);
        @(negedge clk);
        while (cyc < n) @(negedge clk);
    endtask

    // monitor: pops the scoreboard on every handshake seen just before the active edge
    initial begin
        logic       vprev;
        logic [2:0] cprev;
        int         rise_cyc;
        exp_t       e;
        vprev = 1'b0;
        cprev = '0;
        rise_cyc = -1;
        forever begin
            @(negedge clk);
            if (reset) begin
                vprev = 1'b0;
            end else begin
                if (ev_valid && !vprev) rise_cyc = cyc;
                if (ev_valid && vprev) begin
                    vec++;
                    if (ev_code !== cprev) begin
                        errs++;
                        $display("FAIL code_stable: got %0d expected %0d (cycle %0d)", ev_code, cprev, cyc);
                    end
                end
                if (ev_valid && ev_ready) begin
                    vec++;
                    if (sb.size() == 0) begin
                        errs++;
                        $display("FAIL unexpected_event: got code %0d expected none (cycle %0d)", ev_code, cyc);
                    end else begin
                        e = sb.pop_front();
                        if (ev_code !== e.code) begin
                            errs++;
                            $display("FAIL ev_code: got %0d expected %0d (cycle %0d)", ev_code, e.code, cyc);
                        end
                        if (e.rise >= 0) begin
                            vec++;
                            if (rise_cyc != e.rise) begin
                                errs++;
                                $display("FAIL valid_rise: got cycle %0d expected %0d", rise_cyc, e.rise);
                            end
                        end
                    end
                end
                vprev = ev_valid;
                cprev = ev_code;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int j, n;
        // reset values
        at(2);
        chk("rst_valid", ev_valid, 0);
        chk("rst_code", ev_code, 0);
        chk("rst_pend", pendientes, 0);
        chk("rst_perd", perdidos, 0);
        chk("rst_busy", busy, 0);
        drv();
        reset = 1'b0;
        repeat (3) drv();

        // single event: latency, one-cycle valid, busy length
        ev_in = 5'b00100;
        repeat (3) drv();
        ev_in = '0;
        j = cyc;
        push(3'd2, j + 2);
        at(j + 1);
        chk("t1_pend", pendientes, 5'b00100);
        chk("t1_valid_early", ev_valid, 0);
        at(j + 2);
        chk("t1_valid", ev_valid, 1);
        chk("t1_code", ev_code, 2);
        at(j + 3);
        chk("t1_valid_drop", ev_valid, 0);
        chk("t1_pend_clr", pendientes, 0);
        n = busy ? 1 : 0;
        for (int c = j + 4; c <= j + 9; c++) begin
            at(c);
            if (busy) n++;
        end
        chk("t1_busy_cycles", n, 4);
        chk("t1_perd", perdidos, 0);

        // simultaneous edges drain in priority order
        ev_in = 5'b10011;
        repeat (3) drv();
        ev_in = '0;
        j = cyc;
        push(3'd0, j + 2);
        push(3'd1, j + 8);
        push(3'd4, j + 14);
        at(j + 1);
        chk("t2_pend0", pendientes, 5'b10011);
        at(j + 3);
        chk("t2_pend1", pendientes, 5'b10010);
        at(j + 9);
        chk("t2_pend2", pendientes, 5'b10000);
        at(j + 15);
        chk("t2_pend3", pendientes, 5'b00000);
        while (cyc < j + 22) drv();

        // stalled offer is not preempted by a higher-priority arrival
        ev_ready = 1'b0;
        ev_in = 5'b01000;
        repeat (3) drv();
        ev_in = '0;
        j = cyc;
        push(3'd3, j + 2);
        while (cyc < j + 5) drv();
        ev_in[0] = 1'b1;
        while (cyc < j + 8) drv();
        ev_in[0] = 1'b0;
        push(3'd0, j + 28);
        at(j + 10);
        chk("t3_pend", pendientes, 5'b01001);
        chk("t3_valid", ev_valid, 1);
        chk("t3_code", ev_code, 3);
        while (cyc < j + 22) drv();
        ev_ready = 1'b1;
        while (cyc < j + 40) drv();

        // edge on granted source during its handshake re-arms without loss
        ev_in = 5'b00100;
        repeat (3) drv();
        ev_in = '0;
        j = cyc;
        push(3'd2, j + 2);
        drv();
        ev_in = 5'b00100;
        drv();
        ev_in = '0;
        push(3'd2, j + 8);
        at(j + 3);
        chk("t5_pend", pendientes, 5'b00100);
        chk("t5_perd", perdidos, 0);
        chk("t5_valid", ev_valid, 0);
        chk("t5_busy", busy, 1);
        while (cyc < j + 16) drv();

        // coalescing with saturation
        ev_ready = 1'b0;
        push(3'd1, -1);
        for (int i = 0; i < 300; i++) begin
            drv();
            if (i == 100) chk("t4_perd_100", perdidos, 99);
            if (i == 256) chk("t4_perd_256", perdidos, 255);
            ev_in[1] = 1'b1;
            drv();
            ev_in[1] = 1'b0;
        end
        repeat (2) drv();
        chk("t4_perd_sat", perdidos, 255);
        chk("t4_pend", pendientes, 5'b00010);
        chk("t4_valid", ev_valid, 1);
        chk("t4_code", ev_code, 1);
        ev_ready = 1'b1;
        repeat (12) drv();
        chk("t4_pend_clr", pendientes, 0);
        chk("t4_idle", ev_valid, 0);

        // reset during OFFER
        ev_ready = 1'b0;
        ev_in = 5'b11000;
        repeat (3) drv();
        ev_in = '0;
        j = cyc;
        at(j + 3);
        chk("t6_offer_valid", ev_valid, 1);
        chk("t6_offer_pend", pendientes, 5'b11000);
        drv();
        reset = 1'b1;
        #1;
        chk("t6a_valid", ev_valid, 0);
        chk("t6a_code", ev_code, 0);
        chk("t6a_pend", pendientes, 0);
        chk("t6a_perd", perdidos, 0);
        chk("t6a_busy", busy, 0);
        drv();
        reset = 1'b0;
        ev_ready = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (ev_valid) n++;
        end
        chk("t6a_no_event", n, 0);

        // reset during COOLDOWN, then a line held high through reset
        ev_in = 5'b00011;
        repeat (3) drv();
        ev_in = '0;
        j = cyc;
        push(3'd0, j + 2);
        at(j + 4);
        chk("t6b_busy", busy, 1);
        chk("t6b_pend", pendientes, 5'b00010);
        drv();
        ev_in = 5'b10000;
        reset = 1'b1;
        #1;
        chk("t6b_busy_rst", busy, 0);
        chk("t6b_pend_rst", pendientes, 0);
        chk("t6b_valid_rst", ev_valid, 0);
        repeat (2) drv();
        reset = 1'b0;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (ev_valid) n++;
        end
        chk("t6b_no_event", n, 0);
        drv();
        ev_in = '0;
        j = cyc;
        push(3'd4, j + 2);

        n = 0;
        while (sb.size() != 0 && n < 40) begin
            drv();
            n++;
        end
        repeat (3) drv();
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
